// File: rtl/sdram_rom_arb_if.sv
// sdram_rom_arb_if: client and SDRAM ROM-port toggle-handshake bundle for sdram_rom_arb
// Ports: cN_req/cN_addr/cN_din/cN_we from client N, cN_ack/cN_dout back to it (N=0..2);
//        rom_req/rom_addr/rom_din/rom_we to the SDRAM controller, rom_req_ack/rom_dout from it.
// Modports: master = arbiter side, slave = clients plus controller side.
interface sdram_rom_arb_if;
  logic        c0_req, c0_ack, c0_we;
  logic [22:0] c0_addr;
  logic [15:0] c0_din, c0_dout;
  logic        c1_req, c1_ack, c1_we;
  logic [22:0] c1_addr;
  logic [15:0] c1_din, c1_dout;
  logic        c2_req, c2_ack, c2_we;
  logic [22:0] c2_addr;
  logic [15:0] c2_din, c2_dout;
  logic        rom_req, rom_req_ack, rom_we;
  logic [22:0] rom_addr;
  logic [15:0] rom_din, rom_dout;
  modport master (
    input  c0_req, c0_addr, c0_din, c0_we,
    input  c1_req, c1_addr, c1_din, c1_we,
    input  c2_req, c2_addr, c2_din, c2_we,
    input  rom_req_ack, rom_dout,
    output c0_ack, c0_dout, c1_ack, c1_dout, c2_ack, c2_dout,
    output rom_req, rom_addr, rom_din, rom_we
  );
  modport slave (
    output c0_req, c0_addr, c0_din, c0_we,
    output c1_req, c1_addr, c1_din, c1_we,
    output c2_req, c2_addr, c2_din, c2_we,
    output rom_req_ack, rom_dout,
    input  c0_ack, c0_dout, c1_ack, c1_dout, c2_ack, c2_dout,
    input  rom_req, rom_addr, rom_din, rom_we
  );
endinterface

// File: rtl/sdram_rom_arb.sv
// sdram_rom_arb: three-client toggle-handshake arbiter for the SDRAM ROM/bank-0 port
// Ports: clk, init_n (async active-low reset), bus (sdram_rom_arb_if.master: client and ROM-port signals).
// DATA_LAT: cycles from the rom_req_ack toggle to rom_dout valid (1..15).
// Define SDRAM_ARB_RR_EN for round-robin selection; otherwise fixed priority c0 > c1 > c2.
module sdram_rom_arb #(
  parameter int DATA_LAT = 4
) (
  input logic clk,
  input logic init_n,
  sdram_rom_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] req, ack, pend, we;
  logic [2:0][22:0] addr;
  logic [2:0][15:0] din, dout;
  logic [1:0] owner, sel;
  logic [3:0] cnt;
  logic ack_seen, grant, load, fin;
  assign req = {bus.c2_req, bus.c1_req, bus.c0_req};
  assign we = {bus.c2_we, bus.c1_we, bus.c0_we};
  assign addr = {bus.c2_addr, bus.c1_addr, bus.c0_addr};
  assign din = {bus.c2_din, bus.c1_din, bus.c0_din};
  assign pend = req ^ ack;
  assign ack_seen = bus.rom_req_ack == bus.rom_req;
  assign {bus.c2_ack, bus.c1_ack, bus.c0_ack} = ack;
  assign bus.c0_dout = dout[0];
  assign bus.c1_dout = dout[1];
  assign bus.c2_dout = dout[2];
`ifdef SDRAM_ARB_RR_EN
  logic [1:0] last, s0, s1, s2;
  assign s0 = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign s1 = s0 == 2'd2 ? 2'd0 : s0 + 2'd1;
  assign s2 = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
  assign sel = pend[s0] ? s0 : pend[s1] ? s1 : s2;
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) last <= 2'd0;
    else if (grant) last <= sel;
`else
  assign sel = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
`endif
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) state <= IDLE;
    else state <= state_nx;
  // Reads leave WAIT_DATA one cycle early so that the DONE edge, which
  // captures rom_dout and toggles the ack together, lands DATA_LAT cycles
  // after the ack edge; DATA_LAT == 1 therefore skips WAIT_DATA entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = |pend ? WAIT_ACK : IDLE;
      WAIT_ACK:  state_nx = !ack_seen ? WAIT_ACK : (bus.rom_we || DATA_LAT == 1) ? DONE : WAIT_DATA;
      WAIT_DATA: state_nx = cnt == 4'd1 ? DONE : WAIT_DATA;
      default:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    grant = state == IDLE && |pend;
    load = state == WAIT_ACK && ack_seen;
    fin = state == DONE;
  end
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      bus.rom_req <= 1'b0;
      bus.rom_addr <= '0;
      bus.rom_din <= '0;
      bus.rom_we <= 1'b0;
      owner <= 2'd0;
      cnt <= 4'd0;
      ack <= '0;
      dout <= '0;
    end else begin
      if (grant) begin
        bus.rom_req <= ~bus.rom_req;
        bus.rom_addr <= addr[sel];
        bus.rom_din <= din[sel];
        bus.rom_we <= we[sel];
        owner <= sel;
      end
      if (load) cnt <= 4'(DATA_LAT - 1);
      else if (state == WAIT_DATA) cnt <= cnt - 4'd1;
      if (fin) begin
        ack[owner] <= req[owner];
        if (!bus.rom_we) dout[owner] <= bus.rom_dout;
      end
    end
endmodule

// File: tb/tb_sdram_rom_arb.sv
// tb_sdram_rom_arb: randomized and directed checks of sdram_rom_arb against a cycle-level transaction model
module tb_sdram_rom_arb;
  localparam int DL = 4;
  logic clk = 1'b0, init_n = 1'b0;
  always #5 clk = ~clk;
  sdram_rom_arb_if bus();
  sdram_rom_arb #(.DATA_LAT(DL)) dut (.clk(clk), .init_n(init_n), .bus(bus.master));
  logic [2:0] creq = '0, cwe = '0;
  logic [22:0] caddr [3] = '{default: '0};
  logic [15:0] cdin [3] = '{default: '0};
  logic rack = 1'b0;
  logic [15:0] rdout = '0;
  assign bus.c0_req = creq[0];
  assign bus.c1_req = creq[1];
  assign bus.c2_req = creq[2];
  assign bus.c0_we = cwe[0];
  assign bus.c1_we = cwe[1];
  assign bus.c2_we = cwe[2];
  assign bus.c0_addr = caddr[0];
  assign bus.c1_addr = caddr[1];
  assign bus.c2_addr = caddr[2];
  assign bus.c0_din = cdin[0];
  assign bus.c1_din = cdin[1];
  assign bus.c2_din = cdin[2];
  assign bus.rom_req_ack = rack;
  assign bus.rom_dout = rdout;
  logic [2:0] dack;
  logic [15:0] ddout [3];
  assign dack = {bus.c2_ack, bus.c1_ack, bus.c0_ack};
  assign ddout[0] = bus.c0_dout;
  assign ddout[1] = bus.c1_dout;
  assign ddout[2] = bus.c2_dout;
  logic [2:0] mack = '0;
  logic [15:0] mdout [3] = '{default: '0};
  logic mrom_req = 1'b0, m_we = 1'b0, g_we = 1'b0, prev_rr = 1'b0;
  logic [22:0] m_addr = '0, g_addr = '0;
  logic [15:0] m_din = '0, g_din = '0, rd_val = '0;
  logic [2:0] prev_dack = '0;
  int cyc = 0, grant_cyc = -1, ack_cyc = -1, dat_cyc = -1, done_cyc = -1;
  int own = 0, rr_last = 0, ctl_ack_at = 0, dut_done_cyc = 0, hog_n = 0;
  bit busy = 1'b0, hog = 1'b0, rnd = 1'b0;
  logic [22:0] gq [$];
  logic [15:0] mem [logic [22:0]];
  int n_tests = 0, n_fail = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] rdmem(logic [22:0] a);
    return mem.exists(a) ? mem[a] : a[15:0] ^ 16'h3C5A;
  endfunction
  function automatic int pick(logic [2:0] p, int last);
`ifdef SDRAM_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (p[(last + k) % 3]) return (last + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction
  function automatic int find_addr(logic [22:0] a);
    foreach (gq[k]) if (gq[k] == a) return k;
    return -1;
  endfunction
  task automatic issue(int i, logic [22:0] a, logic [15:0] d, logic w);
    caddr[i] = a;
    cdin[i] = d;
    cwe[i] = w;
    creq[i] = ~creq[i];
  endtask
  // Decide the next grant from what the arbiter will see at the coming edge.
  task automatic sched();
    logic [2:0] p;
    p = creq ^ mack;
    if (init_n && !busy && p != 3'b0) begin
      own = pick(p, rr_last);
      rr_last = own;
      g_addr = caddr[own];
      g_din = cdin[own];
      g_we = cwe[own];
      busy = 1'b1;
      grant_cyc = cyc + 1;
      ack_cyc = cyc + 1 + int'($urandom_range(0, 3));
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.rom_req !== prev_rr) begin
      gq.push_back(bus.rom_addr);
      prev_rr = bus.rom_req;
    end
    if (dack !== prev_dack) begin
      dut_done_cyc = cyc;
      prev_dack = dack;
    end
    if (cyc == grant_cyc) begin
      mrom_req = ~mrom_req;
      m_addr = g_addr;
      m_din = g_din;
      m_we = g_we;
    end
    if (cyc == done_cyc) begin
      mack[own] = ~mack[own];
      if (m_we) mem[m_addr] = m_din;
      else mdout[own] = rd_val;
      busy = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("c%0d_ack", i), 32'(dack[i]), 32'(mack[i]));
      check($sformatf("c%0d_dout", i), 32'(ddout[i]), 32'(mdout[i]));
    end
    check("rom_req", 32'(bus.rom_req), 32'(mrom_req));
    check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
    check("rom_din", 32'(bus.rom_din), 32'(m_din));
    check("rom_we", 32'(bus.rom_we), 32'(m_we));
    if (cyc == ack_cyc) begin
      rack = ~rack;
      ctl_ack_at = cyc;
      rd_val = rdmem(m_addr);
      dat_cyc = cyc + DL;
      done_cyc = cyc + (m_we ? 2 : DL + 1);
    end
    rdout = (cyc == dat_cyc && !m_we) ? rd_val : 16'($urandom);
    if (hog && !(creq[0] ^ mack[0])) begin
      issue(0, 23'h300 + 23'(hog_n), 16'h0, 1'b0);
      hog_n++;
    end
    if (rnd)
      for (int i = 0; i < 3; i++)
        if (!(creq[i] ^ mack[i]) && $urandom_range(0, 3) == 0)
          issue(i, 23'($urandom_range(0, 63)), 16'($urandom), 1'($urandom_range(0, 1)));
    sched();
  endtask
  task automatic run_idle(int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((busy || (creq ^ mack) != 3'b0) && k < budget);
    check("timeout", 32'(k < budget), 32'd1);
  endtask
  task automatic reset_model();
    mack = '0;
    mdout = '{default: '0};
    creq = '0;
    rack = 1'b0;
    mrom_req = 1'b0;
    m_addr = '0;
    m_din = '0;
    m_we = 1'b0;
    busy = 1'b0;
    hog = 1'b0;
    rnd = 1'b0;
    grant_cyc = -1;
    ack_cyc = -1;
    dat_cyc = -1;
    done_cyc = -1;
    rr_last = 0;
    prev_rr = 1'b0;
    prev_dack = '0;
  endtask
  initial begin
    int pos, n0;
    int ord [3];
`ifdef SDRAM_ARB_RR_EN
    ord = '{2, 0, 1};
`else
    ord = '{0, 1, 2};
`endif
    reset_model();
    repeat (3) step();
    init_n = 1'b1;
    step();
    mem[23'h000100] = 16'hBEEF;
    issue(0, 23'h000100, 16'h0, 1'b0);
    sched();
    run_idle(100);
    check("rd_data", 32'(bus.c0_dout), 32'h0000BEEF);
    check("rd_lat", 32'(dut_done_cyc - ctl_ack_at), 32'(DL + 1));
    check("rd_c1_quiet", 32'(bus.c1_dout), 32'h0);
    check("rd_c2_quiet", 32'(bus.c2_dout), 32'h0);
    issue(2, 23'h3FFFFF, 16'h5A5A, 1'b1);
    sched();
    run_idle(100);
    check("wr_we", 32'(bus.rom_we), 32'h1);
    check("wr_addr", 32'(bus.rom_addr), 32'h3FFFFF);
    check("wr_din", 32'(bus.rom_din), 32'h5A5A);
    check("wr_lat", 32'(dut_done_cyc - ctl_ack_at), 32'd2);
    check("wr_c2_ack", 32'(bus.c2_ack), 32'h1);
    issue(1, 23'h000010, 16'h0, 1'b0);
    sched();
    run_idle(100);
    gq.delete();
    for (int i = 0; i < 3; i++) issue(i, 23'h200 + 23'(i), 16'(i), 1'b0);
    sched();
    run_idle(200);
    check("order_cnt", 32'(gq.size()), 32'd3);
    for (int k = 0; k < 3; k++) check($sformatf("order%0d", k), 32'(gq[k]), 32'h200 + 32'(ord[k]));
    gq.delete();
    hog_n = 1;
    hog = 1'b1;
    issue(0, 23'h300, 16'h0, 1'b0);
    issue(1, 23'h400, 16'h0, 1'b0);
    sched();
    pos = -1;
    n0 = 0;
    for (int k = 0; k < 400 && pos < 0 && n0 < 6; k++) begin
      step();
      pos = find_addr(23'h400);
      n0 = gq.size() - (pos >= 0 ? 1 : 0);
    end
`ifdef SDRAM_ARB_RR_EN
    check("rr_no_starve", 32'(pos >= 0 && pos <= 1), 32'd1);
`else
    check("fixed_starve", 32'(pos < 0), 32'd1);
    hog = 1'b0;
    run_idle(200);
    check("fixed_release", 32'(find_addr(23'h400) >= 0), 32'd1);
`endif
    hog = 1'b0;
    run_idle(200);
    issue(1, 23'h0ABCDE, 16'h0, 1'b0);
    sched();
    for (int k = 0; k < 50 && cyc <= ack_cyc + 1; k++) step();
    caddr[1] = 23'h111111;
    run_idle(100);
    check("stable_addr", 32'(bus.rom_addr), 32'h0ABCDE);
    check("stable_data", 32'(bus.c1_dout), 32'(rdmem(23'h0ABCDE)));
    issue(0, 23'h000123, 16'h0, 1'b0);
    sched();
    for (int k = 0; k < 50 && cyc <= ack_cyc + 1; k++) step();
    #2 init_n = 1'b0;
    #1;
    check("arst_acks", 32'(dack), 32'h0);
    check("arst_c0_dout", 32'(bus.c0_dout), 32'h0);
    check("arst_c1_dout", 32'(bus.c1_dout), 32'h0);
    check("arst_rom_req", 32'(bus.rom_req), 32'h0);
    check("arst_rom_addr", 32'(bus.rom_addr), 32'h0);
    check("arst_rom_din_we", 32'({bus.rom_din, bus.rom_we}), 32'h0);
    reset_model();
    repeat (2) step();
    init_n = 1'b1;
    issue(1, 23'h000055, 16'h0, 1'b0);
    sched();
    run_idle(100);
    check("post_rst_data", 32'(bus.c1_dout), 32'(rdmem(23'h000055)));
    check("post_rst_ack", 32'(bus.c1_ack), 32'h1);
    rnd = 1'b1;
    repeat (600) step();
    rnd = 1'b0;
    run_idle(300);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
